// File: rtl/alu_pkg.sv
// alu_pkg
// Definitions shared by the accumulator front-end and the combinational ALU
// behind it: FSM state encoding, opcode values and repeat-field width.
package alu_pkg;

  localparam int REP_W = 4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_SHL1 = 3'd6;
  localparam logic [2:0] OP_SHR1 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_accumulator.sv
// alu_accumulator
// Command front-end for the external combinational ALU. Accepts load/ALU
// commands over a valid/ready handshake, keeps an accumulator, applies an
// ALU operation (repeat+1) times, and returns the final value over a second
// valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_load, cmd_op,
//   cmd_data, cmd_repeat     command fields
//   alu_a/alu_b/alu_op       to ALU (registered)
//   alu_result/alu_zero      from ALU (sampled the same cycle)
//   rsp_valid/rsp_ready      response handshake
//   rsp_data/rsp_zero        final accumulator value and its zero flag
//   cmd_count                completed responses, wraps at 2^16
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | ready for a command
// ST_EXEC | writing ALU result into acc once per cycle, rep counts down
// ST_RESP | presenting acc until the consumer takes it
module alu_accumulator
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [REP_W-1:0] cmd_repeat,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic [15:0]      cmd_count
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [REP_W-1:0]   r_rep;
  logic               r_zero;
  logic [15:0]        r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_rep   <= '0;
      r_zero  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op  <= cmd_op;
            r_b   <= cmd_data;
            r_rep <= cmd_repeat;
            if (cmd_load) begin
              r_acc   <= cmd_data;
              r_zero  <= (cmd_data == '0);
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          // alu_a is r_acc, so each cycle feeds the previous result back in.
          r_acc  <= alu_result;
          r_zero <= alu_zero;
          if (r_rep == '0) begin
            r_state <= ST_RESP;
          end else begin
            r_rep <= r_rep - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_count <= r_count + 16'd1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_acc;
  assign rsp_zero  = r_zero;
  assign alu_a     = r_acc;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign cmd_count = r_count;

endmodule

// File: doc/alu_accumulator.md
# alu_accumulator

Sequential command front-end for the team's 8-bit combinational ALU. It accepts operand/opcode commands over a valid/ready handshake and holds an accumulator. It drives the ALU's `a`/`b`/`op` inputs, optionally applies an operation repeatedly, and writes each result back into the accumulator. Each finished command produces a response (result plus zero flag) over a second valid/ready handshake. The block sits directly upstream of the ALU. The ALU's `result`/`zero` outputs come back into this block, and the parent connects the two.

## Interface
- `WIDTH`, 8: datapath width; must match the ALU's width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_load`  in  1  1 = load `cmd_data` into the accumulator; the ALU is not used.
- `cmd_op`  in  3  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL1, 7 SHR1.
- `cmd_data`  in  WIDTH  operand B, or the load value.
- `cmd_repeat`  in  4  number of ALU applications minus 1 (0 = once, 15 = 16 times).
- `alu_a`  out  WIDTH  to ALU `a`; always equals the accumulator.
- `alu_b`  out  WIDTH  to ALU `b`; the registered operand.
- `alu_op`  out  3  to ALU `op`; the registered opcode.
- `alu_result`  in  WIDTH  from ALU `result`.
- `alu_zero`  in  1  from ALU `zero`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  WIDTH  final accumulator value.
- `rsp_zero`  out  1  zero flag of the final value.
- `cmd_count`  out  16  number of completed responses; wraps at 2^16.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_op` into `op_q`, `cmd_data` into `b_q`, and `cmd_repeat` into `rep_q`.
  - If `cmd_load`=1: acc ← `cmd_data`, zero_q ← (`cmd_data`==0), next state RESP.
  - Otherwise: next state EXEC.
- **EXEC**
  - `cmd_ready`=0.
  - Every cycle: acc ← `alu_result`, zero_q ← `alu_zero`.
  - If `rep_q`==0, next state RESP; otherwise `rep_q` decrements and the state stays EXEC.
- **RESP**
  - `rsp_valid`=1, `rsp_data`=acc, `rsp_zero`=zero_q. These values are stable while `rsp_valid`=1 and `rsp_ready`=0.
  - On `rsp_ready`: `cmd_count` increments and the next state is IDLE.
  - `cmd_ready` stays 0 in RESP; a new command is never accepted in the same cycle a response completes.
- Arithmetic:
  - All results are truncated to WIDTH bits; carry and borrow are discarded, as in the ALU.
  - The accumulator persists across commands; only `rst` clears it.
- The ALU is combinational. `alu_a`/`alu_b`/`alu_op` are driven straight from registers, and the ALU output is sampled in the same cycle.
- `rsp_ready` seen outside RESP is ignored. `cmd_valid` seen outside IDLE is ignored; the command is held off by `cmd_ready`=0.
- Reset mid-operation (any state):
  - State → IDLE.
  - acc, `b_q`, `op_q`, `rep_q`, zero_q and `cmd_count` → 0.
  - Any pending response is dropped.

## Timing
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_zero`=0, `alu_a`=0, `alu_b`=0, `alu_op`=0, `cmd_count`=0.
- Load command accepted at edge T: `rsp_valid`=1 from T+1.
- ALU command with repeat R accepted at edge T:
  - EXEC cycles run from T+1 through T+R+1.
  - `rsp_valid`=1 from T+R+2.
- Response completed at edge U (`rsp_valid` & `rsp_ready`): `cmd_ready`=1 from U+1.
- Best-case throughput:
  - Load: one command per 2 cycles.
  - ALU op with R=0: one command per 3 cycles.

## Structure
- Shared package `alu_pkg`:
  - FSM state enum (IDLE/EXEC/RESP).
  - Opcode localparams `OP_ADD`..`OP_SHR1` (3'd0..3'd7), shared with the ALU.
  - Repeat-field width constant (4).
- No sub-module. The ALU instance lives in the parent and is wired to the `alu_*` ports. The testbench instantiates both blocks.

## Test plan
- Reset, then load 8'h05, then ADD `cmd_data`=8'h03 with R=0 → responses 8'h05 (zero=0), then 8'h08 (zero=0); `cmd_count`=2.
- Load 8'h01, then SHL1 with R=7 → `rsp_data`=8'h00, `rsp_zero`=1; `rsp_valid` rises exactly 9 cycles after acceptance.
- Load 8'hFF, then ADD 8'h01 → `rsp_data`=8'h00 and `rsp_zero`=1 (wrap); SUB 8'h01 from 8'h00 → 8'hFF.
- Hold `rsp_ready`=0 for 5 cycles in RESP while `cmd_valid`=1 with new data → `rsp_data` stable, `cmd_ready`=0, no command accepted. Release → `cmd_ready`=1 the next cycle.
- Assert `rst` during EXEC of XOR 8'hAA with R=3 → all outputs return to reset values immediately; the next load 8'h10 responds 8'h10 with `cmd_count`=1.
- Back-to-back random commands with random `rsp_ready` stalls against a reference model → every response matches; `cmd_count` equals the number of handshakes.
